// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional 2-entry skid buffer.
// Define PIPE_STAGE_SKID_EN to build the skid entry and a registered in_ready.
module pipe_stage_reg #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        count
);

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_e;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              push, pop;

  // State encoding doubles as the occupancy count.
  assign count     = state_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_valid ? main_q : BUBBLE_VAL;
  assign pop       = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;

  assign in_ready = in_ready_q;
  assign push     = in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end
`else
  // Without the skid entry a new beat is only taken when the held one leaves.
  assign in_ready = out_ready | ~out_valid;
  assign push     = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (push) begin
          main_d = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    main_q <= main_d;
  end
`endif

endmodule
